simon_game_ctrl: RTL and testbench
==================================

# simon_game_ctrl

Central sequencer for the Simon Says game datapath. It owns the game-level state machine and hands off with the sequence-generate, display, input-capture and check blocks through one-cycle go pulses and done strobes. It also keeps the round counter and the input timeout, and reports win/lose plus a debug state code for the top-level outputs.

## Interface
- MAX_ROUND, 16, rounds per game; a full 32-bit sequence memory holds 16 2-bit colours. Legal range 1..16.
- TIMEOUT_CYCLES, 1000000, cycles allowed in INPUT before the game is lost. Must be ≥2.
- TMR_W, 20, timeout counter width. Must hold TIMEOUT_CYCLES-1.
- clk  in  1  clock; all logic rises on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start_btn  in  1  level from pin, already synchronised; its rising edge starts a game.
- abort  in  1  synchronous abort to IDLE.
- gen_done  in  1  sequence generation and memory load finished (strobe).
- disp_done  in  1  display of round+1 colours finished (strobe).
- input_done  in  1  player entered round+1 colours (strobe).
- check_done  in  1  check result valid (strobe).
- check_pass  in  1  qualifies check_done: 1 = sequence matched.
- gen_go, disp_go, input_go, check_go  out  1 each  one-cycle start pulses to the sub-blocks.
- round  out  4  current round index, 0..MAX_ROUND-1; the display and check blocks use round+1 colours.
- game_won, game_lost  out  1 each  result levels, held until the next game or abort.
- state_dbg  out  3  encoded state: IDLE=0, GEN=1, SHOW=2, INPUT=3, CHECK=4, WIN=5, LOSE=6.

## Operation
- Rising-edge detector on start_btn uses a prev register; prev resets to 1, so a button held through reset does not start a game.
- IDLE: on start edge -> GEN, round=0, clear flags.
- GEN: gen_done -> SHOW.
- SHOW: disp_done -> INPUT, timer cleared to 0.
- INPUT: timer +1 per cycle.
  - input_done -> CHECK.
  - Otherwise timer==TIMEOUT_CYCLES-1 -> LOSE.
  - input_done in the same cycle as the timeout: input_done wins.
- CHECK: on check_done:
  - pass and round==MAX_ROUND-1 -> WIN.
  - pass otherwise -> SHOW with round+1.
  - fail -> LOSE.
- WIN: game_won=1. LOSE: game_lost=1. Both states hold until a start edge, which goes -> GEN with round=0 and flags cleared.
- Go pulses: each is a registered pulse, high for exactly the first cycle of its destination state.
  - gen_go on GEN entry, disp_go on SHOW entry (also SHOW re-entry from CHECK), input_go on INPUT entry, check_go on CHECK entry.
  - Never two go pulses in one cycle.
- Done strobes are honoured only in their own state and only after the go cycle; a done in any other state or cycle is ignored. check_pass is ignored without check_done.
- abort: from any state -> IDLE next cycle. Round, timer, flags and go outputs cleared. A pending go pulse is suppressed. Start edge ignored in the same cycle.
- Priority: rst_n > abort > done/timeout > start edge.
- round never wraps; it is incremented only on the CHECK->SHOW transition.

## Timing
- Reset (rst_n low at posedge): state IDLE, all outputs 0 (state_dbg=0, round=0), timer=0, prev=1.
- Start edge sampled at cycle N: state_dbg=1 and gen_go=1 at N+1.
- Done strobe sampled at cycle N: the next state and its go pulse are visible at N+1. Controller overhead is 1 cycle per hand-off.
- Timeout: input_go at cycle T, LOSE entered at T+TIMEOUT_CYCLES when no input_done arrives.
- game_won/game_lost rise in the first cycle of WIN/LOSE. They fall in the cycle state_dbg becomes 1 or 0.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- Full win, MAX_ROUND=4, each done strobe given 3 cycles after its go:
  - expect 1 gen_go, 4 disp_go, 4 input_go, 4 check_go.
  - round steps 0,1,2,3.
  - game_won=1 with state_dbg=5, then holds.
- Fail at round 2 (check_done=1, check_pass=0) -> state_dbg=6, game_lost=1, round stays 2. A start edge then gives state_dbg=1, round=0, flags cleared.
- Timeout, TIMEOUT_CYCLES=8, no input_done:
  - LOSE exactly 8 cycles after the input_go cycle.
  - Repeat with input_done on the 8th cycle -> CHECK, not LOSE.
- Start_btn held high through reset release -> stays IDLE. Drop then raise it -> GEN one cycle after the rising-edge sample.
- Stray strobes: disp_done in GEN, check_done in INPUT, and gen_done in the gen_go cycle -> no state change, no go pulses.
- abort in each state, including the go cycle -> IDLE next cycle, all outputs 0. abort with simultaneous start edge -> stays IDLE.

Source files
------------

// File: rtl/simon_game_ctrl.sv
// -----------------------------------------------------------------------------
// simon_game_ctrl
//
// Game-level sequencer for the Simon Says datapath. It steps through
// sequence generation, display, player input and checking by sending a
// one-cycle go pulse to each sub-block. It then waits for that block's done
// strobe. The block also keeps the round counter and the input timeout, and
// it reports the game result and a debug state code.
//
// Parameters
//   MAX_ROUND       rounds per game (1..16)
//   TIMEOUT_CYCLES  cycles allowed in INPUT before the game is lost (>= 2)
//   TMR_W           timeout counter width, must hold TIMEOUT_CYCLES-1
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   start_btn    synchronised button level; its rising edge starts a game
//   abort        synchronous return to IDLE
//   gen_done     sequence generation finished (strobe)
//   disp_done    display of round+1 colours finished (strobe)
//   input_done   player entered round+1 colours (strobe)
//   check_done   check result valid (strobe)
//   check_pass   qualifies check_done: 1 = sequence matched
//   gen_go, disp_go, input_go, check_go
//                one-cycle start pulses, high in the first cycle of the state
//   round        current round index 0..MAX_ROUND-1
//   game_won, game_lost
//                result levels, held until the next game or an abort
//   state_dbg    IDLE=0 GEN=1 SHOW=2 INPUT=3 CHECK=4 WIN=5 LOSE=6
// -----------------------------------------------------------------------------
module simon_game_ctrl #(
    parameter int MAX_ROUND      = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMR_W          = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       abort,
    input  logic       gen_done,
    input  logic       disp_done,
    input  logic       input_done,
    input  logic       check_done,
    input  logic       check_pass,
    output logic       gen_go,
    output logic       disp_go,
    output logic       input_go,
    output logic       check_go,
    output logic [3:0] round,
    output logic       game_won,
    output logic       game_lost,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_INPUT = 3'd3,
        S_CHECK = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [3:0]       LAST_ROUND = 4'(MAX_ROUND - 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nx;
    logic [3:0]       round_nx;
    logic [TMR_W-1:0] timer, timer_nx;
    logic             prev;
    logic             start_edge;
    logic             gen_go_nx, disp_go_nx, input_go_nx, check_go_nx;
    logic             won_nx, lost_nx;

    // prev resets to 1. A button held down through reset therefore looks like
    // a level and not an edge.
    assign start_edge = start_btn & ~prev;

    // The state register drives the debug port directly, so the port stays
    // fully registered.
    assign state_dbg = state;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // Each go pulse is computed on the transition into its state and then
    // registered. It is therefore high for exactly the first cycle of that
    // state. A done strobe is accepted only when the state's own go is low,
    // which means after the go cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves
        // one unassigned and no latch is inferred.
        state_nx    = state;
        round_nx    = round;
        timer_nx    = timer;
        gen_go_nx   = 1'b0;
        disp_go_nx  = 1'b0;
        input_go_nx = 1'b0;
        check_go_nx = 1'b0;
        won_nx      = game_won;
        lost_nx     = game_lost;

        if (abort) begin
            // Abort has priority over every strobe and over the start edge. Any
            // go that would have been issued this cycle is dropped.
            state_nx = S_IDLE;
            round_nx = '0;
            timer_nx = '0;
            won_nx   = 1'b0;
            lost_nx  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_edge) begin
                        state_nx  = S_GEN;
                        round_nx  = '0;
                        won_nx    = 1'b0;
                        lost_nx   = 1'b0;
                        gen_go_nx = 1'b1;
                    end
                end

                S_GEN: begin
                    if (gen_done && !gen_go) begin
                        state_nx   = S_SHOW;
                        disp_go_nx = 1'b1;
                    end
                end

                S_SHOW: begin
                    if (disp_done && !disp_go) begin
                        state_nx    = S_INPUT;
                        timer_nx    = '0;
                        input_go_nx = 1'b1;
                    end
                end

                S_INPUT: begin
                    timer_nx = timer + TMR_W'(1);
                    // If input_done and the timeout land in the same cycle,
                    // input_done wins.
                    if (input_done && !input_go) begin
                        state_nx    = S_CHECK;
                        check_go_nx = 1'b1;
                    end else if (timer == TMR_LAST) begin
                        state_nx = S_LOSE;
                        lost_nx  = 1'b1;
                    end
                end

                S_CHECK: begin
                    if (check_done && !check_go) begin
                        if (!check_pass) begin
                            state_nx = S_LOSE;
                            lost_nx  = 1'b1;
                        end else if (round == LAST_ROUND) begin
                            state_nx = S_WIN;
                            won_nx   = 1'b1;
                        end else begin
                            // This is the only place the round advances. It
                            // cannot wrap, because the last round goes to WIN.
                            state_nx   = S_SHOW;
                            round_nx   = round + 4'd1;
                            disp_go_nx = 1'b1;
                        end
                    end
                end

                default: begin
                    state_nx = S_IDLE;
                    round_nx = '0;
                    timer_nx = '0;
                    won_nx   = 1'b0;
                    lost_nx  = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments. Every
        // flop then samples pre-edge values, and simulation matches the
        // synthesised hardware.
        if (!rst_n) begin
            state     <= S_IDLE;
            round     <= '0;
            timer     <= '0;
            prev      <= 1'b1;
            gen_go    <= 1'b0;
            disp_go   <= 1'b0;
            input_go  <= 1'b0;
            check_go  <= 1'b0;
            game_won  <= 1'b0;
            game_lost <= 1'b0;
        end else begin
            state     <= state_nx;
            round     <= round_nx;
            timer     <= timer_nx;
            prev      <= start_btn;
            gen_go    <= gen_go_nx;
            disp_go   <= disp_go_nx;
            input_go  <= input_go_nx;
            check_go  <= check_go_nx;
            game_won  <= won_nx;
            game_lost <= lost_nx;
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_game_ctrl
//
// Directed bench for simon_game_ctrl, built with MAX_ROUND=4 and
// TIMEOUT_CYCLES=8. Inputs change 1 ns after a rising edge. Outputs are
// sampled at the same point, so each tick() shows the registered result of
// the edge just taken.
// -----------------------------------------------------------------------------
module tb_simon_game_ctrl;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start_btn  = 1'b0;
    logic       abort      = 1'b0;
    logic       gen_done   = 1'b0;
    logic       disp_done  = 1'b0;
    logic       input_done = 1'b0;
    logic       check_done = 1'b0;
    logic       check_pass = 1'b0;
    logic       gen_go, disp_go, input_go, check_go;
    logic [3:0] round;
    logic       game_won, game_lost;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;

    // Running counts of go pulses and of cycles with more than one go high.
    int gen_cnt = 0, disp_cnt = 0, input_cnt = 0, check_cnt = 0, multi_cnt = 0;

    simon_game_ctrl #(
        .MAX_ROUND     (4),
        .TIMEOUT_CYCLES(8),
        .TMR_W         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .abort     (abort),
        .gen_done  (gen_done),
        .disp_done (disp_done),
        .input_done(input_done),
        .check_done(check_done),
        .check_pass(check_pass),
        .gen_go    (gen_go),
        .disp_go   (disp_go),
        .input_go  (input_go),
        .check_go  (check_go),
        .round     (round),
        .game_won  (game_won),
        .game_lost (game_lost),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            gen_cnt   <= gen_cnt   + int'(gen_go);
            disp_cnt  <= disp_cnt  + int'(disp_go);
            input_cnt <= input_cnt + int'(input_go);
            check_cnt <= check_cnt + int'(check_go);
            if ($countones({gen_go, disp_go, input_go, check_go}) > 1)
                multi_cnt <= multi_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Checks every output against the expected values. gos is
    // {gen_go, disp_go, input_go, check_go}.
    task automatic expect_out(input string tag, input int st, input int rnd,
                              input logic [3:0] gos, input logic won, input logic lost);
        check({tag, ".state"}, 32'(state_dbg), 32'(st));
        check({tag, ".round"}, 32'(round), 32'(rnd));
        check({tag, ".gos"}, 32'({gen_go, disp_go, input_go, check_go}), 32'(gos));
        check({tag, ".won"}, 32'(game_won), 32'(won));
        check({tag, ".lost"}, 32'(game_lost), 32'(lost));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits dly cycles, then pulses one done strobe for a single cycle.
    // sel: 0=gen 1=disp 2=input 3=check (with check_pass=pass).
    task automatic hand(input int sel, input logic pass, input int dly);
        repeat (dly) tick();
        case (sel)
            0:       gen_done   = 1'b1;
            1:       disp_done  = 1'b1;
            2:       input_done = 1'b1;
            default: begin
                check_done = 1'b1;
                check_pass = pass;
            end
        endcase
        tick();
        gen_done   = 1'b0;
        disp_done  = 1'b0;
        input_done = 1'b0;
        check_done = 1'b0;
        check_pass = 1'b0;
    endtask

    // Drives a fresh rising edge on start_btn. It leaves the DUT in the gen_go
    // cycle.
    task automatic new_game();
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        tick();
    endtask

    task automatic play_rounds(input int n);
        for (int i = 0; i < n; i++) begin
            hand(1, 1'b0, 1);
            hand(2, 1'b0, 1);
            hand(3, 1'b1, 1);
        end
    endtask

    task automatic abort_chk(input string tag);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expect_out(tag, 0, 0, 4'b0000, 1'b0, 1'b0);
    endtask

    int g0, d0, i0, c0;

    initial begin
        // ---------------- reset ----------------
        repeat (2) tick();
        expect_out("reset", 0, 0, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("idle_after_reset", 0, 0, 4'b0000, 1'b0, 1'b0);

        // ---------------- full win, MAX_ROUND=4 ----------------
        g0 = gen_cnt; d0 = disp_cnt; i0 = input_cnt; c0 = check_cnt;
        new_game();
        expect_out("win.gen", 1, 0, 4'b1000, 1'b0, 1'b0);
        hand(0, 1'b0, 3);
        expect_out("win.show0", 2, 0, 4'b0100, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            hand(1, 1'b0, 3);
            expect_out($sformatf("win.input%0d", r), 3, r, 4'b0010, 1'b0, 1'b0);
            hand(2, 1'b0, 3);
            expect_out($sformatf("win.check%0d", r), 4, r, 4'b0001, 1'b0, 1'b0);
            hand(3, 1'b1, 3);
            if (r < 3)
                expect_out($sformatf("win.show%0d", r + 1), 2, r + 1, 4'b0100, 1'b0, 1'b0);
            else
                expect_out("win.won", 5, 3, 4'b0000, 1'b1, 1'b0);
        end
        repeat (5) tick();
        expect_out("win.hold", 5, 3, 4'b0000, 1'b1, 1'b0);
        check("win.gen_cnt", 32'(gen_cnt - g0), 32'd1);
        check("win.disp_cnt", 32'(disp_cnt - d0), 32'd4);
        check("win.input_cnt", 32'(input_cnt - i0), 32'd4);
        check("win.check_cnt", 32'(check_cnt - c0), 32'd4);

        // ---------------- fail at round 2 ----------------
        start_btn = 1'b0;
        tick();
        expect_out("fail.btn_low", 5, 3, 4'b0000, 1'b1, 1'b0);
        start_btn = 1'b1;
        tick();
        expect_out("fail.gen", 1, 0, 4'b1000, 1'b0, 1'b0);
        hand(0, 1'b0, 1);
        play_rounds(2);
        expect_out("fail.show2", 2, 2, 4'b0100, 1'b0, 1'b0);
        hand(1, 1'b0, 1);
        hand(2, 1'b0, 1);
        hand(3, 1'b0, 1);
        expect_out("fail.lose", 6, 2, 4'b0000, 1'b0, 1'b1);
        repeat (3) tick();
        expect_out("fail.hold", 6, 2, 4'b0000, 1'b0, 1'b1);
        new_game();
        expect_out("fail.restart", 1, 0, 4'b1000, 1'b0, 1'b0);

        // ---------------- timeout ----------------
        hand(0, 1'b0, 1);
        hand(1, 1'b0, 1);
        expect_out("to.input_go", 3, 0, 4'b0010, 1'b0, 1'b0);
        repeat (7) tick();
        expect_out("to.last_cycle", 3, 0, 4'b0000, 1'b0, 1'b0);
        tick();
        expect_out("to.lose", 6, 0, 4'b0000, 1'b0, 1'b1);

        // An input_done during the input_go cycle is ignored. An input_done on
        // the timeout cycle beats the timeout.
        new_game();
        hand(0, 1'b0, 1);
        hand(1, 1'b0, 1);
        expect_out("to2.input_go", 3, 0, 4'b0010, 1'b0, 1'b0);
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
        expect_out("to2.stray_in_go", 3, 0, 4'b0000, 1'b0, 1'b0);
        repeat (6) tick();
        input_done = 1'b1;
        tick();
        input_done = 1'b0;
        expect_out("to2.check", 4, 0, 4'b0001, 1'b0, 1'b0);
        hand(3, 1'b0, 1);
        expect_out("to2.lose", 6, 0, 4'b0000, 1'b0, 1'b1);

        // ---------------- start held through reset ----------------
        rst_n     = 1'b0;
        start_btn = 1'b1;
        tick();
        expect_out("rst2.reset", 0, 0, 4'b0000, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        expect_out("rst2.held", 0, 0, 4'b0000, 1'b0, 1'b0);
        start_btn = 1'b0;
        tick();
        expect_out("rst2.drop", 0, 0, 4'b0000, 1'b0, 1'b0);
        start_btn = 1'b1;
        tick();
        expect_out("rst2.gen", 1, 0, 4'b1000, 1'b0, 1'b0);

        // ---------------- stray strobes ----------------
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        expect_out("stray.gen_in_go", 1, 0, 4'b0000, 1'b0, 1'b0);
        disp_done = 1'b1;
        tick();
        disp_done = 1'b0;
        expect_out("stray.disp_in_gen", 1, 0, 4'b0000, 1'b0, 1'b0);
        hand(0, 1'b0, 1);
        hand(1, 1'b0, 1);
        tick();
        check_done = 1'b1;
        check_pass = 1'b1;
        tick();
        check_done = 1'b0;
        check_pass = 1'b0;
        expect_out("stray.check_in_input", 3, 0, 4'b0000, 1'b0, 1'b0);
        hand(2, 1'b0, 1);
        expect_out("stray.check_state", 4, 0, 4'b0001, 1'b0, 1'b0);
        check_pass = 1'b1;
        tick();
        check_pass = 1'b0;
        expect_out("stray.pass_alone", 4, 0, 4'b0000, 1'b0, 1'b0);

        // ---------------- abort ----------------
        abort_chk("ab.check");
        abort_chk("ab.idle");
        new_game();
        abort_chk("ab.gen_go");
        new_game();
        hand(0, 1'b0, 1);
        abort_chk("ab.show_go");
        new_game();
        tick();
        gen_done = 1'b1;
        abort    = 1'b1;
        tick();
        gen_done = 1'b0;
        abort    = 1'b0;
        expect_out("ab.pending_go", 0, 0, 4'b0000, 1'b0, 1'b0);
        new_game();
        hand(0, 1'b0, 1);
        hand(1, 1'b0, 1);
        abort_chk("ab.input_go");
        new_game();
        hand(0, 1'b0, 1);
        hand(1, 1'b0, 1);
        repeat (2) tick();
        abort_chk("ab.input");
        new_game();
        hand(0, 1'b0, 1);
        play_rounds(4);
        expect_out("ab.win_reached", 5, 3, 4'b0000, 1'b1, 1'b0);
        abort_chk("ab.win");
        new_game();
        hand(0, 1'b0, 1);
        play_rounds(1);
        hand(1, 1'b0, 1);
        hand(2, 1'b0, 1);
        hand(3, 1'b0, 1);
        expect_out("ab.lose_reached", 6, 1, 4'b0000, 1'b0, 1'b1);
        abort_chk("ab.lose");

        // Abort together with a start edge: stays in IDLE, and the held
        // button does not count as a later edge.
        start_btn = 1'b0;
        tick();
        start_btn = 1'b1;
        abort     = 1'b1;
        tick();
        abort = 1'b0;
        expect_out("ab.with_start", 0, 0, 4'b0000, 1'b0, 1'b0);
        repeat (2) tick();
        expect_out("ab.with_start_hold", 0, 0, 4'b0000, 1'b0, 1'b0);

        tick();
        check("no_double_go", 32'(multi_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
